// File: rtl/tt_access_arbiter.sv
// rtl/tt_access_arbiter.sv - time base and round-robin access arbiter for the TR/IO trigger register bank
//
// Ports:
//   clk, rst (sync, active low)
//   time_en, time_load, time_load_val, tick_div -> g_time, g_tick   : prescaled global time base
//   req/we/sel/num/wdata 0,1 (0 = CP2, 1 = config loader)            : access requests
//   gnt0/1, rvalid0/1, rdata                                         : per-requester handshake, shared read data
//   wea, rea, w_sel, r_sel, w_number, r_number, din, dout            : bank access port
module tt_access_arbiter #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  time_en,
    input  logic                  time_load,
    input  logic [31:0]           time_load_val,
    input  logic [PRESCALE_W-1:0] tick_div,
    output logic [31:0]           g_time,
    output logic                  g_tick,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  sel0,
    input  logic [4:0]            num0,
    input  logic [31:0]           wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  sel1,
    input  logic [4:0]            num1,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata,
    output logic                  wea,
    output logic                  rea,
    output logic                  w_sel,
    output logic                  r_sel,
    output logic [4:0]            w_number,
    output logic [4:0]            r_number,
    output logic [31:0]           din,
    input  logic [31:0]           dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  last;     // last granted requester
    logic                  cur;      // requester owning the access in flight
    logic                  cur_we;
    logic                  any_req;
    logic                  win;
    logic                  launch;
    logic                  c_we;
    logic                  c_sel;
    logic [4:0]            c_num;
    logic [31:0]           c_wdata;

    // Time base. Using >= lets a lowered tick_div cut the current period short.
    always_ff @(posedge clk) begin
        if (!rst) begin
            g_time <= '0;
            g_tick <= 1'b0;
            pcnt   <= '0;
        end else begin
            g_tick <= 1'b0;
            if (time_load) begin
                g_time <= time_load_val;
                pcnt   <= '0;
            end else if (time_en && (pcnt >= tick_div)) begin
                g_time <= g_time + 32'd1;
                g_tick <= 1'b1;
                pcnt   <= '0;
            end else if (time_en) begin
                pcnt <= pcnt + PRESCALE_W'(1);
            end
        end
    end

    // Arbitration and next state. A tie goes to whoever was not served last.
    always_comb begin
        any_req  = req0 | req1;
        win      = (req0 && req1) ? ~last : req1;
        c_we     = win ? we1    : we0;
        c_sel    = win ? sel1   : sel0;
        c_num    = win ? num1   : num0;
        c_wdata  = win ? wdata1 : wdata0;
        launch   = 1'b0;
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    launch   = 1'b1;
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: state_nx = S_GAP;
            S_GAP: begin
                if (any_req) begin
                    launch   = 1'b1;
                    state_nx = S_ACCESS;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Bank controls and grants are registered so they line up with the ACCESS
    // cycle; read data is captured at the end of ACCESS and flagged during GAP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last     <= 1'b1;
            cur      <= 1'b0;
            cur_we   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
            wea      <= 1'b0;
            rea      <= 1'b0;
            w_sel    <= 1'b0;
            r_sel    <= 1'b0;
            w_number <= '0;
            r_number <= '0;
            din      <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            wea     <= 1'b0;
            rea     <= 1'b0;
            if (launch) begin
                cur    <= win;
                cur_we <= c_we;
                gnt0   <= ~win;
                gnt1   <= win;
                if (c_we) begin
                    wea      <= 1'b1;
                    w_sel    <= c_sel;
                    w_number <= c_num;
                    din      <= c_wdata;
                end else begin
                    rea      <= 1'b1;
                    r_sel    <= c_sel;
                    r_number <= c_num;
                end
            end
            if (state == S_ACCESS) begin
                last <= cur;
                if (!cur_we) begin
                    rdata   <= dout;
                    rvalid0 <= ~cur;
                    rvalid1 <= cur;
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_access_arbiter.sv
// tb/tb_tt_access_arbiter.sv - self-checking bench for tt_access_arbiter
module tb_tt_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        time_en, time_load;
    logic [31:0] time_load_val;
    logic [7:0]  tick_div;
    logic [31:0] g_time;
    logic        g_tick;
    logic        req0, we0, sel0, req1, we1, sel1;
    logic [4:0]  num0, num1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        wea, rea, w_sel, r_sel;
    logic [4:0]  w_number, r_number;
    logic [31:0] din, dout;

    int   checks = 0;
    int   errors = 0;
    logic exp_last;   // model: requester served most recently

    always #5 clk = ~clk;

    tt_access_arbiter #(.PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst),
        .time_en(time_en), .time_load(time_load), .time_load_val(time_load_val),
        .tick_div(tick_div), .g_time(g_time), .g_tick(g_tick),
        .req0(req0), .we0(we0), .sel0(sel0), .num0(num0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .sel1(sel1), .num1(num1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .wea(wea), .rea(rea), .w_sel(w_sel), .r_sel(r_sel),
        .w_number(w_number), .r_number(r_number), .din(din), .dout(dout)
    );

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; time_en = 1'b0; time_load = 1'b0; time_load_val = '0; tick_div = '0;
        req0 = 0; we0 = 0; sel0 = 0; num0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; sel1 = 0; num1 = '0; wdata1 = '0;
        dout = '0;
        tick; tick;
        exp_last = 1'b1;
        checks++;
        if ({g_time, g_tick, gnt0, gnt1, rvalid0, rvalid1, rdata, wea, rea, w_sel, r_sel,
             w_number, r_number, din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: g_time=%h rdata=%h din=%h ctl=%b required all zero",
                     g_time, rdata, din, {g_tick, gnt0, gnt1, rvalid0, rvalid1, wea, rea, w_sel, r_sel});
        end
        rst = 1'b1;
    endtask

    task automatic test_time_base;
        int          n, div;
        logic [31:0] val, exp_t;
        logic        en, exp_tick;
        // Fixed divider of 3 from reset: one tick every 4 cycles.
        time_en = 1'b1; tick_div = 8'd3;
        for (int i = 1; i <= 20; i++) begin
            tick;
            exp_t = 32'(i / 4);
            exp_tick = (i % 4 == 0);
            checks++;
            if (g_time !== exp_t || g_tick !== exp_tick) begin
                errors++;
                $display("FAIL time_div3 cyc %0d: g_time=%h g_tick=%b required %h %b", i, g_time, g_tick, exp_t, exp_tick);
            end
        end
        // Random load value, divider and enable gaps.
        for (int r = 0; r < 3; r++) begin
            div = $urandom_range(0, 5);
            val = $urandom;
            time_load = 1'b1; time_load_val = val; tick_div = 8'(div);
            tick;
            checks++;
            if (g_time !== val || g_tick !== 1'b0) begin
                errors++;
                $display("FAIL time_load: g_time=%h g_tick=%b required %h 0", g_time, g_tick, val);
            end
            time_load = 1'b0;
            n = 0;
            for (int i = 0; i < 30; i++) begin
                en = ($urandom_range(0, 3) != 0);
                time_en = en;
                tick;
                if (en) n++;
                exp_t = val + 32'(n / (div + 1));
                exp_tick = en && (n % (div + 1) == 0);
                checks++;
                if (g_time !== exp_t || g_tick !== exp_tick) begin
                    errors++;
                    $display("FAIL time_rand div %0d n %0d: g_time=%h g_tick=%b required %h %b",
                             div, n, g_time, g_tick, exp_t, exp_tick);
                end
            end
        end
        // Lowering the divider mid-count takes effect on the next enabled cycle.
        time_load = 1'b1; time_load_val = 32'h100; tick_div = 8'd7; time_en = 1'b1;
        tick;
        time_load = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        tick_div = 8'd2;
        tick;
        checks++;
        if (g_time !== 32'h101 || g_tick !== 1'b1) begin
            errors++;
            $display("FAIL time_div_drop: g_time=%h g_tick=%b required 00000101 1", g_time, g_tick);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_t;
        time_en = 1'b1; tick_div = 8'd0; time_load = 1'b1; time_load_val = 32'hFFFF_FFFE;
        tick;
        time_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_t = 32'hFFFF_FFFE + 32'(i);
            checks++;
            if (g_time !== exp_t) begin
                errors++;
                $display("FAIL time_wrap step %0d: g_time=%h required %h", i, g_time, exp_t);
            end
            tick;
        end
        time_en = 1'b0;
    endtask

    task automatic test_write;
        req0 = 1; we0 = 1; sel0 = 1; num0 = 5'd8; wdata0 = 32'h5;
        tick;
        checks++;
        if ({wea, rea, w_sel, w_number, din, gnt0, gnt1} !== {1'b1, 1'b0, 1'b1, 5'd8, 32'h5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_access: wea=%b rea=%b w_sel=%b w_number=%0d din=%h gnt=%b%b required 1 0 1 8 5 gnt0",
                     wea, rea, w_sel, w_number, din, gnt0, gnt1);
        end
        exp_last = 1'b0;
        req0 = 0;
        tick;
        checks++;
        if ({wea, gnt0, gnt1, rvalid0, rvalid1} !== 5'b0) begin
            errors++;
            $display("FAIL write_gap: wea=%b gnt=%b%b rvalid=%b%b required all 0", wea, gnt0, gnt1, rvalid0, rvalid1);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic w;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        sel0 = 1'($urandom); num0 = 5'($urandom); wdata0 = $urandom;
        sel1 = 1'($urandom); num1 = 5'($urandom); wdata1 = $urandom;
        for (int k = 0; k < 8; k++) begin
            tick;
            w = ~exp_last;
            checks++;
            if (gnt0 !== ~w || gnt1 !== w || wea !== 1'b1 ||
                din !== (w ? wdata1 : wdata0) || w_number !== (w ? num1 : num0) || w_sel !== (w ? sel1 : sel0)) begin
                errors++;
                $display("FAIL b2b_access %0d: gnt=%b%b wea=%b din=%h num=%0d required winner %0d wea 1 din %h num %0d",
                         k, gnt0, gnt1, wea, din, w_number, w, (w ? wdata1 : wdata0), (w ? num1 : num0));
            end
            exp_last = w;
            if (w) begin
                sel1 = 1'($urandom); num1 = 5'($urandom); wdata1 = $urandom;
            end else begin
                sel0 = 1'($urandom); num0 = 5'($urandom); wdata0 = $urandom;
            end
            if (k == 7) begin
                req0 = 0; req1 = 0;
            end
            tick;
            checks++;
            if ({wea, gnt0, gnt1} !== 3'b0) begin
                errors++;
                $display("FAIL b2b_gap %0d: wea=%b gnt=%b%b required 0 00", k, wea, gnt0, gnt1);
            end
        end
        tick;
    endtask

    task automatic test_read;
        logic        who, s;
        logic [4:0]  nm;
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                who = 1; s = 0; nm = 5'd1; d = 32'hA5A5;
            end else begin
                who = 1'($urandom); s = 1'($urandom); nm = 5'($urandom); d = $urandom;
            end
            if (who) begin req1 = 1; we1 = 0; sel1 = s; num1 = nm; end
            else     begin req0 = 1; we0 = 0; sel0 = s; num0 = nm; end
            dout = d;
            tick;
            checks++;
            if (rea !== 1'b1 || wea !== 1'b0 || r_sel !== s || r_number !== nm || gnt0 !== ~who || gnt1 !== who) begin
                errors++;
                $display("FAIL read_access %0d: rea=%b wea=%b r_sel=%b r_number=%0d gnt=%b%b required 1 0 %b %0d winner %0d",
                         i, rea, wea, r_sel, r_number, gnt0, gnt1, s, nm, who);
            end
            exp_last = who;
            req0 = 0; req1 = 0;
            tick;
            checks++;
            if (rvalid0 !== ~who || rvalid1 !== who || rdata !== d || rea !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL read_gap %0d: rvalid=%b%b rdata=%h rea=%b required requester %0d rdata %h rea 0",
                         i, rvalid0, rvalid1, rdata, rea, who, d);
            end
            dout = $urandom;
            tick;
            checks++;
            if (rdata !== d || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                errors++;
                $display("FAIL read_hold %0d: rdata=%h rvalid=%b%b required %h 00", i, rdata, rvalid0, rvalid1, d);
            end
        end
    endtask

    task automatic test_load_with_access;
        logic [31:0] val;
        val = $urandom;
        req0 = 1; we0 = 1; sel0 = 0; num0 = 5'd3; wdata0 = 32'h1234;
        time_load = 1; time_load_val = val;
        tick;
        checks++;
        if (g_time !== val || wea !== 1'b1 || gnt0 !== 1'b1 || din !== 32'h1234) begin
            errors++;
            $display("FAIL load_and_access: g_time=%h wea=%b gnt0=%b din=%h required %h 1 1 00001234",
                     g_time, wea, gnt0, din, val);
        end
        exp_last = 1'b0;
        time_load = 0; req0 = 0;
        tick; tick;
    endtask

    task automatic test_reset_mid;
        req0 = 1; we0 = 0; sel0 = 1; num0 = 5'd9; dout = 32'hDEAD_BEEF;
        tick;
        checks++;
        if (rea !== 1'b1 || gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_access: rea=%b gnt0=%b required 1 1", rea, gnt0);
        end
        rst = 0; req0 = 0;
        tick;
        exp_last = 1'b1;
        checks++;
        if ({g_time, g_tick, gnt0, gnt1, rvalid0, rvalid1, rdata, wea, rea, w_sel, r_sel,
             w_number, r_number, din} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: g_time=%h rdata=%h din=%h ctl=%b required all zero",
                     g_time, rdata, din, {g_tick, gnt0, gnt1, rvalid0, rvalid1, wea, rea, w_sel, r_sel});
        end
        rst = 1;
        tick;
        checks++;
        if ({rvalid0, rvalid1, gnt0, gnt1, rea, wea} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_nopulse: rvalid=%b%b gnt=%b%b rea=%b wea=%b required all 0",
                     rvalid0, rvalid1, gnt0, gnt1, rea, wea);
        end
        // Back in IDLE with the pointer reset: requester 0 wins the first tie next cycle.
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; wdata0 = 32'h77; wdata1 = 32'h88;
        tick;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || wea !== 1'b1 || din !== 32'h77) begin
            errors++;
            $display("FAIL rstmid_first_tie: gnt=%b%b wea=%b din=%h required 10 1 00000077", gnt0, gnt1, wea, din);
        end
        req0 = 0; req1 = 0;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_time_base;
        test_wrap;
        test_write;
        test_back_to_back;
        test_read;
        test_load_with_access;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
